// File: rtl/bmd_256_lat_pkg.sv
// -----------------------------------------------------------------------------
// bmd_256_lat_pkg
// Shared constants and types for the echo-latency read path.
//   ECHO_TRANS_COUNTER_WIDTH : timestamp / latency width
//   LAT_ADDR_W               : timestamp BRAM address width (8192 entries)
//   LAT_BRAM_RD_LAT          : BRAM port-B read latency in clk cycles
//   lat_t / LAT_MIN_INIT     : latency word and the "no sample yet" minimum
// -----------------------------------------------------------------------------
package bmd_256_lat_pkg;

  localparam int ECHO_TRANS_COUNTER_WIDTH = 40;
  localparam int LAT_ADDR_W               = 13;
  localparam int LAT_BRAM_RD_LAT          = 2;

  typedef logic [ECHO_TRANS_COUNTER_WIDTH-1:0] lat_t;

  localparam lat_t LAT_MIN_INIT = '1;

endpackage

// File: rtl/bmd_256_latency_reader_if.sv
// -----------------------------------------------------------------------------
// bmd_256_latency_reader_if
// Echo input, timestamp-BRAM read port and per-packet latency result.
//   echo_valid/echo_addr     : one returning echo and its sequence address
//   bram_reb/bram_rd_addr    : BRAM port-B enable and address
//   bram_rd_data             : BRAM port-B data
//   lat_valid/lat_value      : one-cycle strobe with the measured latency
// master = environment (RX engine + BRAM), slave = latency reader.
// -----------------------------------------------------------------------------
interface bmd_256_latency_reader_if #(
  parameter int CNT_W  = 40,
  parameter int ADDR_W = 13
);

  logic              echo_valid;
  logic [ADDR_W-1:0] echo_addr;
  logic              bram_reb;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [CNT_W-1:0]  bram_rd_data;
  logic              lat_valid;
  logic [CNT_W-1:0]  lat_value;

  modport master (
    output echo_valid, echo_addr, bram_rd_data,
    input  bram_reb, bram_rd_addr, lat_valid, lat_value
  );

  modport slave (
    input  echo_valid, echo_addr, bram_rd_data,
    output bram_reb, bram_rd_addr, lat_valid, lat_value
  );

endinterface

// File: rtl/bmd_256_lat_stats.sv
// -----------------------------------------------------------------------------
// bmd_256_lat_stats
// Registers each latency sample and keeps running min/max/sum/count.
//   clk, clr            : clock, synchronous clear (rst or user stats clear)
//   in_valid, in_diff   : aligned latency sample
//   lat_valid/lat_value : registered sample strobe and value
//   lat_min/lat_max     : extremes since clear (min starts at all ones)
//   lat_sum/lat_num     : saturating sum and sample count
// -----------------------------------------------------------------------------
module bmd_256_lat_stats #(
  parameter int CNT_W = 40,
  parameter int SUM_W = 64,
  parameter int NUM_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [CNT_W-1:0] in_diff,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_value,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [SUM_W-1:0] lat_sum,
  output logic [NUM_W-1:0] lat_num
);

  logic             valid_d, valid_q;
  logic [CNT_W-1:0] value_d, value_q;
  logic [CNT_W-1:0] min_d, min_q;
  logic [CNT_W-1:0] max_d, max_q;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic [NUM_W-1:0] num_d, num_q;
  logic [SUM_W:0]   sum_ext;

  // Sum one bit wider so the carry-out detects saturation.
  assign sum_ext = {1'b0, sum_q} + {{(SUM_W+1-CNT_W){1'b0}}, in_diff};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    valid_d = in_valid;
    value_d = value_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    num_d   = num_q;
    if (in_valid) begin
      value_d = in_diff;
      if (in_diff < min_q) min_d = in_diff;
      if (in_diff > max_q) max_d = in_diff;
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      num_d = (num_q == '1) ? num_q : num_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      value_q <= '0;
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      num_q   <= '0;
    end else begin
      valid_q <= valid_d;
      value_q <= value_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      num_q   <= num_d;
    end
  end

  assign lat_valid = valid_q;
  assign lat_value = value_q;
  assign lat_min   = min_q;
  assign lat_max   = max_q;
  assign lat_sum   = sum_q;
  assign lat_num   = num_q;

endmodule

// File: rtl/bmd_256_latency_reader.sv
// -----------------------------------------------------------------------------
// bmd_256_latency_reader
// RX-side reader of the echo-latency timestamp BRAM. Each echo reads the send
// timestamp, the capture of latency_counter is delayed to line up with the
// BRAM read latency, and the modular difference becomes the packet latency
// (3 cycles from echo to lat_valid). Fully pipelined, one echo per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   latency_reset_signal : user stats clear; discards in-flight samples
//   latency_counter      : free-running timestamp counter
//   lat_if (slave)       : echo in, BRAM port B, lat_valid/lat_value out
//   lat_min/max/sum/num  : running statistics since clear
//   seq_err_cnt          : out-of-order echo count (saturating)
// Optional: define BMD_LAT_SEQ_CHECK_EN to enable the sequence-address check;
// otherwise seq_err_cnt is tied to 0.
// -----------------------------------------------------------------------------
module bmd_256_latency_reader
  import bmd_256_lat_pkg::*;
#(
  parameter int CNT_W  = ECHO_TRANS_COUNTER_WIDTH,
  parameter int ADDR_W = LAT_ADDR_W,
  parameter int RD_LAT = LAT_BRAM_RD_LAT,
  parameter int SUM_W  = 64,
  parameter int NUM_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        latency_reset_signal,
  input  logic [CNT_W-1:0]            latency_counter,
  bmd_256_latency_reader_if.slave     lat_if,
  output logic [CNT_W-1:0]            lat_min,
  output logic [CNT_W-1:0]            lat_max,
  output logic [SUM_W-1:0]            lat_sum,
  output logic [NUM_W-1:0]            lat_num,
  output logic [15:0]                 seq_err_cnt
);

  logic clr;
  logic accept;

  assign clr    = rst | latency_reset_signal;
  assign accept = lat_if.echo_valid & ~clr;

  assign lat_if.bram_reb     = accept;
  assign lat_if.bram_rd_addr = lat_if.echo_addr;

  // Timestamp delay line matching the BRAM read latency.
  logic [RD_LAT-1:0] vld_d, vld_q;
  logic [CNT_W-1:0]  ts_d [RD_LAT];
  logic [CNT_W-1:0]  ts_q [RD_LAT];

  always_comb begin
    for (int i = RD_LAT - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      ts_d[i]  = ts_q[i-1];
    end
    vld_d[0] = accept;
    ts_d[0]  = latency_counter;
  end

  always_ff @(posedge clk) begin
    if (clr) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // NOTE: the timestamp words carry no reset; they are only consumed when the
  // matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    ts_q <= ts_d;
  end

  logic             sample_valid;
  logic [CNT_W-1:0] sample_diff;

  // Modular subtract absorbs counter wrap between send and echo.
  assign sample_valid = vld_q[RD_LAT-1];
  assign sample_diff  = ts_q[RD_LAT-1] - lat_if.bram_rd_data;

  bmd_256_lat_stats #(
    .CNT_W (CNT_W),
    .SUM_W (SUM_W),
    .NUM_W (NUM_W)
  ) u_stats (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (sample_valid),
    .in_diff   (sample_diff),
    .lat_valid (lat_if.lat_valid),
    .lat_value (lat_if.lat_value),
    .lat_min   (lat_min),
    .lat_max   (lat_max),
    .lat_sum   (lat_sum),
    .lat_num   (lat_num)
  );

`ifdef BMD_LAT_SEQ_CHECK_EN
  logic [ADDR_W-1:0] exp_addr_d, exp_addr_q;
  logic [15:0]       seq_err_d, seq_err_q;

  // A mismatch resyncs to the received address so one lost echo counts once.
  always_comb begin
    exp_addr_d = exp_addr_q;
    seq_err_d  = seq_err_q;
    if (accept) begin
      if (lat_if.echo_addr != exp_addr_q) begin
        if (seq_err_q != '1) seq_err_d = seq_err_q + 16'd1;
        exp_addr_d = lat_if.echo_addr + 1'b1;
      end else begin
        exp_addr_d = exp_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      exp_addr_q <= '0;
      seq_err_q  <= '0;
    end else begin
      exp_addr_q <= exp_addr_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign seq_err_cnt = seq_err_q;
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_bmd_256_latency_reader.sv
// -----------------------------------------------------------------------------
// tb_bmd_256_latency_reader
// Directed bench for bmd_256_latency_reader with a 2-cycle BRAM model.
// Expected values are hand-computed; sequence-error expectations follow
// BMD_LAT_SEQ_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_bmd_256_latency_reader;
  import bmd_256_lat_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        latency_reset_signal;
  lat_t        latency_counter;
  lat_t        lat_min, lat_max;
  logic [63:0] lat_sum;
  logic [31:0] lat_num;
  logic [15:0] seq_err_cnt;

  bmd_256_latency_reader_if #(.CNT_W(40), .ADDR_W(13)) lat_if ();

  bmd_256_latency_reader dut (
    .clk                  (clk),
    .rst                  (rst),
    .latency_reset_signal (latency_reset_signal),
    .latency_counter      (latency_counter),
    .lat_if               (lat_if.slave),
    .lat_min              (lat_min),
    .lat_max              (lat_max),
    .lat_sum              (lat_sum),
    .lat_num              (lat_num),
    .seq_err_cnt          (seq_err_cnt)
  );

  always #5 clk = ~clk;

  // Timestamp BRAM model: data appears two cycles after bram_reb.
  lat_t mem [8192];
  lat_t rd1, rd2;
  always @(posedge clk) begin
    if (lat_if.bram_reb) rd1 <= mem[lat_if.bram_rd_addr];
    rd2 <= rd1;
  end
  assign lat_if.bram_rd_data = rd2;

  // Strobe monitor, sampled mid-cycle.
  int   cyc = 0;
  lat_t got_val [$];
  int   got_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (lat_if.lat_valid) begin
      got_val.push_back(lat_if.lat_value);
      got_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic step(input logic v, input logic [12:0] a, input lat_t c, input logic clr_in);
    lat_if.echo_valid    = v;
    lat_if.echo_addr     = a;
    latency_counter      = c;
    latency_reset_signal = clr_in;
    @(posedge clk);
    #1;
    lat_if.echo_valid    = 1'b0;
    latency_reset_signal = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 13'd0, 40'd0, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_num"}, 64'(lat_num), 64'd0);
    check({tag, "_min"}, 64'(lat_min), 64'(LAT_MIN_INIT));
    check({tag, "_max"}, 64'(lat_max), 64'd0);
    check({tag, "_sum"}, lat_sum, 64'd0);
  endtask

`ifdef BMD_LAT_SEQ_CHECK_EN
  localparam logic [15:0] SEQ_EXP = 16'd1;
`else
  localparam logic [15:0] SEQ_EXP = 16'd0;
`endif

  int issue;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    rst                  = 1'b1;
    latency_reset_signal = 1'b0;
    latency_counter      = '0;
    lat_if.echo_valid    = 1'b1;
    lat_if.echo_addr     = 13'd3;
    repeat (3) @(posedge clk);
    #1;
    // Reset state; echo during reset must not reach the BRAM.
    check("rst_reb", 64'(lat_if.bram_reb), 64'd0);
    check("rst_valid", 64'(lat_if.lat_valid), 64'd0);
    check("rst_value", 64'(lat_if.lat_value), 64'd0);
    check("rst_seq", 64'(seq_err_cnt), 64'd0);
    check_cleared("rst");
    rst               = 1'b0;
    lat_if.echo_valid = 1'b0;
    idle(2);

    // Single echo: 130 - 100 = 30, strobe 3 cycles after issue.
    mem[5] = 40'd100;
    got_val.delete(); got_cyc.delete();
    issue = cyc;
    lat_if.echo_valid = 1'b1; lat_if.echo_addr = 13'd5; latency_counter = 40'd130;
    #1;
    check("t1_reb", 64'(lat_if.bram_reb), 64'd1);
    check("t1_addr", 64'(lat_if.bram_rd_addr), 64'd5);
    step(1'b1, 13'd5, 40'd130, 1'b0);
    idle(5);
    check("t1_count", 64'(got_val.size()), 64'd1);
    if (got_val.size() >= 1) begin
      check("t1_value", 64'(got_val[0]), 64'd30);
      check("t1_latency", 64'(got_cyc[0] - issue), 64'd3);
    end
    check("t1_min", 64'(lat_min), 64'd30);
    check("t1_max", 64'(lat_max), 64'd30);
    check("t1_sum", lat_sum, 64'd30);
    check("t1_num", 64'(lat_num), 64'd1);

    // User clear: stats back to reset values on the next cycle.
    step(1'b0, 13'd0, 40'd0, 1'b1);
    check_cleared("clr");

    // Back-to-back: 50-10, 51-20, 52-30.
    mem[0] = 40'd10; mem[1] = 40'd20; mem[2] = 40'd30;
    got_val.delete(); got_cyc.delete();
    issue = cyc;
    step(1'b1, 13'd0, 40'd50, 1'b0);
    step(1'b1, 13'd1, 40'd51, 1'b0);
    step(1'b1, 13'd2, 40'd52, 1'b0);
    idle(6);
    check("t2_count", 64'(got_val.size()), 64'd3);
    if (got_val.size() >= 3) begin
      check("t2_v0", 64'(got_val[0]), 64'd40);
      check("t2_v1", 64'(got_val[1]), 64'd31);
      check("t2_v2", 64'(got_val[2]), 64'd22);
      check("t2_first", 64'(got_cyc[0] - issue), 64'd3);
      check("t2_span", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
    end
    check("t2_min", 64'(lat_min), 64'd22);
    check("t2_max", 64'(lat_max), 64'd40);
    check("t2_sum", lat_sum, 64'd93);
    check("t2_num", 64'(lat_num), 64'd3);

    // Counter wrap, then a zero-latency sample.
    step(1'b0, 13'd0, 40'd0, 1'b1);
    mem[7] = 40'hFF_FFFF_FFF0;
    mem[9] = 40'd55;
    got_val.delete(); got_cyc.delete();
    step(1'b1, 13'd7, 40'h10, 1'b0);
    idle(5);
    check("t3_count", 64'(got_val.size()), 64'd1);
    if (got_val.size() >= 1) check("t3_wrap", 64'(got_val[0]), 64'h20);
    step(1'b1, 13'd9, 40'd55, 1'b0);
    idle(5);
    check("t3_zero", 64'(lat_if.lat_value), 64'd0);
    check("t3_min", 64'(lat_min), 64'd0);
    check("t3_max", 64'(lat_max), 64'h20);
    check("t3_sum", lat_sum, 64'h20);
    check("t3_num", 64'(lat_num), 64'd2);

    // Clear one cycle after an echo: sample discarded.
    got_val.delete(); got_cyc.delete();
    step(1'b1, 13'd5, 40'd200, 1'b0);
    step(1'b0, 13'd0, 40'd0, 1'b1);
    check_cleared("t4");
    idle(5);
    check("t4_count", 64'(got_val.size()), 64'd0);
    check("t4_num_late", 64'(lat_num), 64'd0);

    // Echo and clear in the same cycle: no BRAM read, no sample.
    got_val.delete(); got_cyc.delete();
    lat_if.echo_valid = 1'b1; lat_if.echo_addr = 13'd5; latency_reset_signal = 1'b1;
    #1;
    check("t5_reb", 64'(lat_if.bram_reb), 64'd0);
    step(1'b1, 13'd5, 40'd300, 1'b1);
    idle(5);
    check("t5_count", 64'(got_val.size()), 64'd0);
    check("t5_num", 64'(lat_num), 64'd0);

    // Sequence check: 0,1,3,4 gives one error; samples still produced.
    step(1'b0, 13'd0, 40'd0, 1'b1);
    step(1'b1, 13'd0, 40'd100, 1'b0);
    step(1'b1, 13'd1, 40'd100, 1'b0);
    step(1'b1, 13'd3, 40'd100, 1'b0);
    step(1'b1, 13'd4, 40'd100, 1'b0);
    idle(5);
    check("t6_seq", 64'(seq_err_cnt), 64'(SEQ_EXP));
    check("t6_num", 64'(lat_num), 64'd4);
    // 8191 resyncs once; 8191 -> 0 -> 1 wraps without further errors.
    step(1'b0, 13'd0, 40'd0, 1'b1);
    check("t6_seq_clr", 64'(seq_err_cnt), 64'd0);
    step(1'b1, 13'd8191, 40'd100, 1'b0);
    step(1'b1, 13'd0, 40'd100, 1'b0);
    step(1'b1, 13'd1, 40'd100, 1'b0);
    idle(5);
    check("t6_seq_wrap", 64'(seq_err_cnt), 64'(SEQ_EXP));
    check("t6_num_wrap", 64'(lat_num), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
